ramtest_bist: RTL and testbench

- Self-checking SRAM test master; successor to the free-running LED RAM exerciser.
- Drives a ramcon-style Wishbone slave port: pipelined strobe with stall, single outstanding transaction.
- Runs a four-pass march over a parametrised address range and compares every read.
- Reports pass/fail, a saturating error count, first-failure details and a bus-timeout flag. Intended for the board's SRAM bring-up and regression in simulation.

---
 rtl/ramtest_bist.sv | 193 +++++++++++++++++++
 tb/tb_ramtest_bist.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramtest_bist.sv
// ramtest_bist: self-checking SRAM march tester driving a pipelined Wishbone
// master port with a single outstanding transaction. The march has four
// passes: write P(a), read P(a), write ~P(a), read ~P(a). It reports
// pass/fail, a saturating mismatch count, details of the first mismatch and a
// bus-timeout abort flag.
module ramtest_bist #(
    parameter int              AW        = 19,
    parameter int              DW        = 16,
    parameter logic [AW-1:0]   ADDR_LAST = {AW{1'b1}},
    parameter int              TIMEOUT   = 255,
    parameter int              ERRW      = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [ERRW-1:0]   err_count_o,
    output logic [AW-1:0]     err_adr_o,
    output logic [DW-1:0]     err_exp_o,
    output logic [DW-1:0]     err_got_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [DW/8-1:0]   sel_o,
    output logic [AW-1:0]     adr_o,
    output logic [DW-1:0]     dat_o,
    input  logic              ack_i,
    input  logic [DW-1:0]     dat_i,
    input  logic              stall_i
);

    // Watchdog wide enough to hold TIMEOUT-1; abort fires on the TIMEOUT-th
    // consecutive waiting cycle.
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [AW-1:0]     addr_q,    addr_d;
    logic [1:0]        pass_q,    pass_d;
    logic [WDW-1:0]    wdog_q,    wdog_d;
    logic              timeout_q, timeout_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0]     err_adr_q, err_adr_d;
    logic [DW-1:0]     err_exp_q, err_exp_d;
    logic [DW-1:0]     err_got_q, err_got_d;

    logic [AW+DW-1:0]  pat_wide;
    logic [DW-1:0]     pattern;
    logic              wdog_expired;
    logic              is_read_pass;
    logic              in_bus;

    // Pattern for the current address: zero-extend/truncate, inverted in passes 2 and 3.
    always_comb begin
        pat_wide     = {{DW{1'b0}}, addr_q};
        pattern      = pass_q[1] ? ~pat_wide[DW-1:0] : pat_wide[DW-1:0];
        wdog_expired = (wdog_q == WDOG_LAST);
        is_read_pass = pass_q[0];
    end

    // Next-state logic: march sequencing, read compare and watchdog.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pass_d    = pass_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        err_cnt_d = err_cnt_q;
        err_adr_d = err_adr_q;
        err_exp_d = err_exp_q;
        err_got_d = err_got_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_REQ;
                    addr_d    = '0;
                    pass_d    = 2'd0;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                    err_cnt_d = '0;
                    err_adr_d = '0;
                    err_exp_d = '0;
                    err_got_d = '0;
                end
            end

            S_REQ: begin
                if (!stall_i) begin
                    state_d = S_WAIT;
                    wdog_d  = '0;
                end else if (wdog_expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            S_WAIT: begin
                if (ack_i) begin
                    if (is_read_pass && (dat_i != pattern)) begin
                        if (err_cnt_q != {ERRW{1'b1}}) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (err_cnt_q == '0) begin
                            err_adr_d = addr_q;
                            err_exp_d = pattern;
                            err_got_d = dat_i;
                        end
                    end
                    wdog_d = '0;
                    // Compare against ADDR_LAST rather than counting past it,
                    // so a full 2**AW range cannot overflow the counter.
                    if (addr_q == ADDR_LAST) begin
                        addr_d = '0;
                        if (pass_q == 2'd3) begin
                            state_d = S_DONE;
                        end else begin
                            pass_d  = pass_q + 2'd1;
                            state_d = S_REQ;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_REQ;
                    end
                end else if (wdog_expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any run in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pass_q    <= 2'd0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
            err_exp_q <= '0;
            err_got_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pass_q    <= pass_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            err_cnt_q <= err_cnt_d;
            err_adr_q <= err_adr_d;
            err_exp_q <= err_exp_d;
            err_got_q <= err_got_d;
        end
    end

    // Bus and status outputs decoded from state; bus fields are quiet outside a cycle.
    always_comb begin
        in_bus      = (state_q == S_REQ) || (state_q == S_WAIT);
        cyc_o       = in_bus;
        stb_o       = (state_q == S_REQ);
        busy_o      = in_bus;
        done_o      = (state_q == S_DONE);
        we_o        = in_bus && !is_read_pass;
        sel_o       = {(DW/8){in_bus}};
        adr_o       = addr_q;
        dat_o       = (in_bus && !is_read_pass) ? pattern : '0;
        timeout_o   = timeout_q;
        fail_o      = timeout_q || (err_cnt_q != '0);
        err_count_o = err_cnt_q;
        err_adr_o   = err_adr_q;
        err_exp_o   = err_exp_q;
        err_got_o   = err_got_q;
    end

endmodule

// File: tb/tb_ramtest_bist.sv
// tb_ramtest_bist: drives ramtest_bist (and a narrow-counter twin sharing the
// same bus responses) through a randomised-memory Wishbone slave model and
// checks results against a march model computed from the test rules.
module tb_ramtest_bist;

    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int NWORDS  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_i = 1'b0;
    logic              ack_i = 1'b0;
    logic [DW-1:0]     dat_i = '0;
    logic              stall_i;

    logic              busy_o, done_o, fail_o, timeout_o, cyc_o, stb_o, we_o;
    logic [15:0]       err_count_o;
    logic [AW-1:0]     err_adr_o, adr_o;
    logic [DW-1:0]     err_exp_o, err_got_o, dat_o;
    logic [1:0]        sel_o;

    logic              s_busy, s_done, s_fail, s_timeout, s_cyc, s_stb, s_we;
    logic [3:0]        s_err_count;
    logic [AW-1:0]     s_err_adr, s_adr;
    logic [DW-1:0]     s_err_exp, s_err_got, s_dat;
    logic [1:0]        s_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model controls
    int fault_mode = 0;   // 0 ideal, 1 bit3 stuck at 0, 2 inverted reads
    int stall_n    = 0;
    bit no_ack     = 1'b0;

    logic [DW-1:0] mem [0:255];
    int stall_cnt = 0;
    int txn_idx   = 0;
    int ack_cnt   = 0;

    always #5 clk = ~clk;

    ramtest_bist #(.AW(AW), .DW(DW), .ADDR_LAST(8'd15), .TIMEOUT(TIMEOUT), .ERRW(16)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .err_count_o(err_count_o), .err_adr_o(err_adr_o), .err_exp_o(err_exp_o),
        .err_got_o(err_got_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .stall_i(stall_i)
    );

    ramtest_bist #(.AW(AW), .DW(DW), .ADDR_LAST(8'd15), .TIMEOUT(TIMEOUT), .ERRW(4)) u_sat (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .busy_o(s_busy), .done_o(s_done), .fail_o(s_fail), .timeout_o(s_timeout),
        .err_count_o(s_err_count), .err_adr_o(s_err_adr), .err_exp_o(s_err_exp),
        .err_got_o(s_err_got), .cyc_o(s_cyc), .stb_o(s_stb), .we_o(s_we),
        .sel_o(s_sel), .adr_o(s_adr), .dat_o(s_dat),
        .ack_i(ack_i), .dat_i(dat_i), .stall_i(stall_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] corrupt(input int mode, input logic [DW-1:0] v);
        case (mode)
            1:       return v & 16'hFFF7;
            2:       return ~v;
            default: return v;
        endcase
    endfunction

    // Reference: walk both read passes and collect the mismatches a given fault produces.
    task automatic model_errs(input int mode, output int cnt, output int first_a,
                              output logic [DW-1:0] first_exp, output logic [DW-1:0] first_got);
        cnt = 0; first_a = 0; first_exp = '0; first_got = '0;
        for (int p = 1; p <= 3; p += 2) begin
            for (int a = 0; a < NWORDS; a++) begin
                logic [DW-1:0] e;
                logic [DW-1:0] g;
                e = (p == 3) ? ~DW'(a) : DW'(a);
                g = corrupt(mode, e);
                if (g != e) begin
                    if (cnt == 0) begin first_a = a; first_exp = e; first_got = g; end
                    cnt++;
                end
            end
        end
    endtask

    // Slave stall: hold each new request off for stall_n cycles.
    assign stall_i = cyc_o && stb_o && (stall_cnt < stall_n);

    // Pipelined slave: accept on stb without stall, ack on the following cycle.
    always @(posedge clk) begin
        ack_i <= 1'b0;
        if (reset_i) begin
            stall_cnt <= 0;
            txn_idx   <= 0;
        end else begin
            if (start_i && !busy_o) begin
                txn_idx <= 0;
                ack_cnt <= 0;
            end
            if (cyc_o && stb_o) begin
                if (stall_i) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    txn_idx   <= txn_idx + 1;
                    if (we_o) mem[adr_o] <= dat_o;
                    else      dat_i <= corrupt(fault_mode, mem[adr_o]);
                    if (!no_ack) begin
                        ack_i   <= 1'b1;
                        ack_cnt <= ack_cnt + 1;
                    end
                end
            end
        end
    end

    // Bus monitor: request stability, one idle strobe cycle between requests, march order.
    bit             in_req = 1'b0;
    bit             have_prev = 1'b0;
    int             gap = 0;
    logic [31:0]    snap;
    int             m_pass, m_a;
    bit             m_we;
    logic [DW-1:0]  m_dat;
    always @(negedge clk) begin
        if (!reset_i && cyc_o && stb_o) begin
            if (!in_req) begin
                in_req = 1'b1;
                snap = {7'd0, we_o, adr_o, dat_o};
                if (have_prev && !no_ack) chk("stb_gap", gap, 1);
                have_prev = 1'b1;
                gap = 0;
            end else begin
                chk("stall_hold", {7'd0, we_o, adr_o, dat_o}, snap);
            end
            if (!stall_i) begin
                m_pass = txn_idx / NWORDS;
                m_a    = txn_idx % NWORDS;
                m_we   = (m_pass % 2) == 0;
                m_dat  = !m_we ? 16'h0 : (m_pass == 0 ? DW'(m_a) : ~DW'(m_a));
                chk("txn_fields", {5'd0, sel_o, we_o, adr_o, dat_o},
                    {5'd0, 2'b11, m_we, AW'(m_a), m_dat});
                $display("txn %0d pass=%0d adr=%02h we=%0b dat=%04h", txn_idx, m_pass, adr_o, we_o, dat_o);
            end
        end else begin
            in_req = 1'b0;
            if (cyc_o && !stb_o) gap++;
            else if (!cyc_o) begin have_prev = 1'b0; gap = 0; end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output int wait_cyc);
        cycles = 0; wait_cyc = 0;
        while (!done_o && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (cyc_o && !stb_o) wait_cyc++;
        end
        chk("done_in_budget", done_o, 1);
    endtask

    // Full run with a given fault; checks both instances against the model.
    task automatic run_check(input string nm, input int mode, input int stalls, input bit mid_start);
        int cyc_n, wc, exp_cnt, exp_a;
        logic [DW-1:0] exp_e, exp_g;
        fault_mode = mode; stall_n = stalls; no_ack = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom);
        model_errs(mode, exp_cnt, exp_a, exp_e, exp_g);
        pulse_start();
        chk({nm, "_busy_after_start"}, {busy_o, done_o, cyc_o, stb_o}, 4'b1011);
        if (mid_start) begin
            repeat (20) @(negedge clk);
            start_i = 1'b1;
            @(negedge clk) start_i = 1'b0;
            chk({nm, "_start_ignored"}, busy_o, 1);
        end
        wait_done(2000, cyc_n, wc);
        if (stalls == 0 && !mid_start) chk({nm, "_throughput"}, cyc_n <= 64 * 3 + 4, 1);
        chk({nm, "_acks"}, ack_cnt, 64);
        chk({nm, "_idle_bus"}, {busy_o, cyc_o, stb_o, timeout_o}, 4'b0000);
        chk({nm, "_err_count"}, err_count_o, exp_cnt);
        chk({nm, "_fail"}, fail_o, exp_cnt != 0);
        chk({nm, "_sat_count"}, s_err_count, (exp_cnt > 15) ? 15 : exp_cnt);
        if (exp_cnt != 0) begin
            chk({nm, "_err_adr"}, err_adr_o, exp_a);
            chk({nm, "_err_exp"}, err_exp_o, exp_e);
            chk({nm, "_err_got"}, err_got_o, exp_g);
            chk({nm, "_sat_first"}, {s_err_adr, s_err_exp, s_err_got}, {AW'(exp_a), exp_e, exp_g});
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {busy_o, done_o, fail_o, timeout_o, cyc_o, stb_o, we_o, sel_o}, 0);
        chk({nm, "_err"}, {err_count_o, err_adr_o}, 0);
        chk({nm, "_errdat"}, {err_exp_o, err_got_o}, 0);
        chk({nm, "_bus"}, {adr_o, dat_o}, 0);
    endtask

    initial begin
        int cyc_n, wc, guard;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_i = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {busy_o, done_o}, 2'b00);

        run_check("clean", 0, 0, 1'b0);
        run_check("stuck3", 1, 0, 1'b0);
        run_check("stall", 0, 3, 1'b1);

        // Slave never acknowledges: abort after TIMEOUT waiting cycles.
        fault_mode = 0; stall_n = 0; no_ack = 1'b1;
        pulse_start();
        wait_done(200, cyc_n, wc);
        chk("to_wait_cycles", wc, TIMEOUT);
        chk("to_flags", {timeout_o, fail_o, done_o, cyc_o, stb_o, busy_o}, 6'b111000);
        chk("to_err_count", err_count_o, 0);
        no_ack = 1'b0;

        // Reset in the middle of pass 2 of a faulty run, then a clean rerun.
        fault_mode = 1; stall_n = 0;
        pulse_start();
        guard = 0;
        while (txn_idx < 40 && guard < 500) begin @(negedge clk); guard++; end
        chk("reach_pass2", txn_idx >= 40, 1);
        chk("pre_reset_errs", err_count_o != 0, 1);
        reset_i = 1'b1;
        @(negedge clk);
        chk_zero("midreset");
        reset_i = 1'b0;
        @(negedge clk);
        run_check("rerun", 0, 0, 1'b0);

        run_check("invert", 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
